// File: rtl/memory_access_unit.sv
// memory_access_unit: single-outstanding load/store bridge from the pipeline to a word-wide bus.
// Optional feature macro MEM_ACCESS_TIMEOUT_EN adds a bus watchdog aborting after TIMEOUT_CYCLES.
`ifndef LOAD_B
`define LOAD_B  3'd0
`endif
`ifndef LOAD_H
`define LOAD_H  3'd1
`endif
`ifndef LOAD_W
`define LOAD_W  3'd2
`endif
`ifndef LOAD_BU
`define LOAD_BU 3'd4
`endif
`ifndef LOAD_HU
`define LOAD_HU 3'd5
`endif

module memory_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_offset,
    output logic [2:0]  rsp_type,
    output logic        rsp_store,
    output logic [1:0]  rsp_exc
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [1:0] EXC_NONE  = 2'd0;
    localparam logic [1:0] EXC_ALIGN = 2'd1;
    localparam logic [1:0] EXC_BUS   = 2'd2;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("memory_access_unit: TIMEOUT_CYCLES must be 1..65535");
    end

    state_t     state;
    logic [1:0] off;
    logic       is_half;
    logic       is_word;
    logic       misaligned;
    logic [3:0] store_be;

    assign off       = req_addr[1:0];
    assign req_ready = (state == IDLE);

    // Store codes are fixed (SB/SH/SW); load codes come from the decoder's header.
    always_comb begin
        is_half = 1'b0;
        is_word = 1'b0;
        if (req_store) begin
            is_half = (req_type == 3'd1);
            is_word = (req_type == 3'd2);
        end else begin
            case (req_type)
                `LOAD_H, `LOAD_HU: is_half = 1'b1;
                `LOAD_W:           is_word = 1'b1;
                default:           ;
            endcase
        end
    end

    // An access is misaligned exactly when it would cross the word boundary.
    assign misaligned = (is_word && off != 2'd0) || (is_half && off == 2'd3);
    assign store_be   = is_word ? 4'hF : (is_half ? (4'b0011 << off) : (4'b0001 << off));

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  EXC_TO  = 2'd3;
    logic [15:0] bus_cnt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_be     <= 4'd0;
            bus_wdata  <= 32'd0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'd0;
            rsp_offset <= 2'd0;
            rsp_type   <= 3'd0;
            rsp_store  <= 1'b0;
            rsp_exc    <= EXC_NONE;
`ifdef MEM_ACCESS_TIMEOUT_EN
            bus_cnt    <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rsp_store  <= req_store;
                        rsp_type   <= req_type;
                        rsp_offset <= off;
                        rsp_rdata  <= 32'd0;
                        bus_addr   <= {req_addr[31:2], 2'b00};
                        bus_we     <= req_store;
                        bus_be     <= req_store ? store_be : 4'hF;
                        bus_wdata  <= req_store ? (req_wdata << {off, 3'b000}) : 32'd0;
                        if (misaligned) begin
                            rsp_exc   <= EXC_ALIGN;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            rsp_exc   <= EXC_NONE;
                            bus_req   <= 1'b1;
                            state     <= BUS;
`ifdef MEM_ACCESS_TIMEOUT_EN
                            bus_cnt   <= 16'd0;
`endif
                        end
                    end
                end
                BUS: begin
                    // An ack in the same cycle as the watchdog expiry still completes normally.
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        rsp_rdata <= bus_we ? 32'd0 : bus_rdata;
                        rsp_exc   <= bus_err ? EXC_BUS : EXC_NONE;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    else if (bus_cnt == TO_LAST) begin
                        bus_req   <= 1'b0;
                        rsp_exc   <= EXC_TO;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        bus_cnt <= bus_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
